// File: rtl/armleocpu_cache_arbiter_pkg.sv
// Shared definitions for the two-port cache arbiter: cache command encoding,
// FSM state encoding and a small state helper.
package armleocpu_cache_arbiter_pkg;

    localparam int CACHE_CMD_W = 4;

    localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CACHE_CMD_LOAD      = 4'd2;
    localparam logic [3:0] CACHE_CMD_STORE     = 4'd3;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY0 = 2'd1,
        ARB_BUSY1 = 2'd2
    } arb_state_t;

    // BUSY state that owns the port selected by idx.
    function automatic arb_state_t busy_state(input logic idx);
        return idx ? ARB_BUSY1 : ARB_BUSY0;
    endfunction

endpackage

// File: rtl/armleocpu_cache_arbiter_if.sv
// Cache command port bundle, used both for requester ports and the cache port.
// Handshake: master holds cmd/address/store_* stable from the first non-NONE cycle
// until the cycle where done=1; response/load_data are valid only when done=1;
// done is never raised in reply to a NONE cycle.
interface armleocpu_cache_arbiter_if #(
    parameter int CMD_W = 4
);
    logic [CMD_W-1:0] cmd;
    logic [31:0]      address;
    logic [31:0]      store_data;
    logic [3:0]       store_be;
    logic             done;
    logic [3:0]       response;
    logic [31:0]      load_data;

    modport master (
        output cmd, address, store_data, store_be,
        input  done, response, load_data
    );

    modport slave (
        input  cmd, address, store_data, store_be,
        output done, response, load_data
    );
endinterface

// File: rtl/armleocpu_arbiter_pick2.sv
// Combinational two-way picker: single requester wins outright; on a tie the
// port other than last_grant wins in round-robin mode, port 1 otherwise.
module armleocpu_arbiter_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = req[1];
        if (req == 2'b11) begin
            gnt_idx = rr_en ? ~last_grant : 1'b1;
        end
    end

endmodule

// File: rtl/armleocpu_cache_arbiter.sv
// Shares one cache command port between fetch (port 0) and load/store/debug (port 1).
// Grant is locked per transaction; the grant-cycle command reaches the cache combinationally.
module armleocpu_cache_arbiter
    import armleocpu_cache_arbiter_pkg::*;
#(
    parameter bit PRIORITY_RR = 1'b1,
    parameter int CMD_W       = CACHE_CMD_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    armleocpu_cache_arbiter_if.slave      r0,
    armleocpu_cache_arbiter_if.slave      r1,
    armleocpu_cache_arbiter_if.master     c,
    output logic                          arb_busy,
    output logic                          arb_error,
    output arb_state_t                    dbg_state
);

    localparam logic [CMD_W-1:0] CMD_NONE = CMD_W'(CACHE_CMD_NONE);

    arb_state_t state, state_nxt;
    logic       last_grant, last_grant_nxt;
    logic [1:0] req;
    logic       gnt_valid, gnt_idx;
    logic       arb_point;
    logic       sel, issue;

    assign req = {r1.cmd != CMD_NONE, r0.cmd != CMD_NONE};

    // IDLE arbitrates every cycle; a BUSY state arbitrates only in its done cycle,
    // which is what gives back-to-back issue without a bubble.
    assign arb_point = (state == ARB_IDLE) || c.done;

    armleocpu_arbiter_pick2 u_pick (
        .req       (req),
        .last_grant(last_grant),
        .rr_en     (PRIORITY_RR),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            arb_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if ((state == ARB_IDLE) && c.done) begin
                arb_error <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (arb_point) begin
            if (gnt_valid) begin
                state_nxt      = busy_state(gnt_idx);
                last_grant_nxt = gnt_idx;
            end else begin
                state_nxt      = ARB_IDLE;
            end
        end
    end

    // Output logic
    always_comb begin
        sel   = 1'b0;
        issue = 1'b1;
        if (arb_point) begin
            sel   = gnt_idx;
            issue = gnt_valid;
        end else begin
            sel   = (state == ARB_BUSY1);
        end

        c.cmd        = CMD_NONE;
        c.address    = 32'h0;
        c.store_data = 32'h0;
        c.store_be   = 4'h0;
        r0.done      = 1'b0;
        r1.done      = 1'b0;
        if (rst_n) begin
            c.cmd        = issue ? (sel ? r1.cmd : r0.cmd) : CMD_NONE;
            c.address    = sel ? r1.address    : r0.address;
            c.store_data = sel ? r1.store_data : r0.store_data;
            c.store_be   = sel ? r1.store_be   : r0.store_be;
            r0.done      = (state == ARB_BUSY0) && c.done;
            r1.done      = (state == ARB_BUSY1) && c.done;
        end

        // Response payload is broadcast; only done is steered to the owner.
        r0.response  = c.response;
        r0.load_data = c.load_data;
        r1.response  = c.response;
        r1.load_data = c.load_data;

        arb_busy     = rst_n && (state != ARB_IDLE);
    end

    assign dbg_state = state;

endmodule
